// File: rtl/note_div_pkg.sv
// Shared definitions for the tone-to-divider arbiter and its serial divider.
package note_div_pkg;

  // Default numerator of the tone-to-divider conversion.
  localparam int unsigned DIVIDEND_DEF = 50_000_000;

  // Default width of each output divider value.
  localparam int OUT_W_DEF = 22;

  // Width of the raw tone frequency inputs.
  localparam int FREQ_W = 32;

  // Quotient bits produced by the default divider: ceil(log2(DIVIDEND+1)).
  localparam int DIV_ITERS = $clog2(64'(DIVIDEND_DEF) + 64'd1);

  // Divider value written for a silent (zero-frequency) channel.
  localparam int SILENCE = 1;

  // Octave select codes; every other code means "normal".
  localparam logic [2:0] OCT_DOWN = 3'd1;
  localparam logic [2:0] OCT_UP   = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DIV,
    ST_WRITE
  } state_t;

  typedef enum logic {
    CH_L = 1'b0,
    CH_R = 1'b1
  } chan_t;

  // Octave-adjusted frequency; the left shift drops bits shifted past bit 31.
  function automatic logic [FREQ_W-1:0] eff_freq(input logic [FREQ_W-1:0] freq,
                                                 input logic [2:0]        octave);
    case (octave)
      OCT_DOWN: return freq >> 1;
      OCT_UP:   return freq << 1;
      default:  return freq;
    endcase
  endfunction

endpackage

// File: rtl/serial_divider.sv
// Iterative restoring divider: one quotient bit per clock, N bits total.
module serial_divider
  import note_div_pkg::*;
#(
  parameter int N  = DIV_ITERS,
  parameter int DW = FREQ_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  dividend,
  input  logic [DW-1:0] divisor,
  output logic [N-1:0]  quotient,
  output logic          done
);

  localparam int CW = $clog2(N + 1);

  // r_quo starts as the dividend; its MSB feeds the remainder while quotient
  // bits shift in at the LSB, so after N steps it holds the quotient.
  logic [N-1:0]  r_quo;
  logic [DW:0]   r_rem;
  logic [DW-1:0] r_dvs;
  logic [CW-1:0] r_cnt;
  logic          r_done;

  logic [DW+1:0] w_trial;
  logic [DW+1:0] w_sub;
  logic          w_ge;
  logic [DW:0]   w_next_rem;

  // The remainder stays below the divisor, so the trial fits and the top bit
  // of the difference is a clean borrow flag.
  assign w_trial    = {r_rem, r_quo[N-1]};
  assign w_sub      = w_trial - {2'b00, r_dvs};
  assign w_ge       = ~w_sub[DW+1];
  assign w_next_rem = w_ge ? w_sub[DW:0] : w_trial[DW:0];

  // Load on start, then one restoring step per cycle until the count expires.
  always_ff @(posedge clk) begin
    // NOTE: the datapath registers are reset as well so a division cut short
    // by rst leaves no partial quotient behind.
    if (rst) begin
      r_quo  <= '0;
      r_rem  <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (start) begin
      r_quo  <= dividend;
      r_rem  <= '0;
      r_dvs  <= divisor;
      r_cnt  <= CW'(N);
      r_done <= 1'b0;
    end else if (r_cnt != '0) begin
      r_quo  <= {r_quo[N-2:0], w_ge};
      r_rem  <= w_next_rem;
      r_cnt  <= r_cnt - 1'b1;
      r_done <= (r_cnt == CW'(1));
    end
  end

  assign quotient = r_quo;
  assign done     = r_done;

endmodule

// File: rtl/note_div_arbiter.sv
// Converts two tone frequencies into note-generator divider values, sharing a
// single serial divider between the left and right channels.
module note_div_arbiter
  import note_div_pkg::*;
#(
  parameter int unsigned DIVIDEND = DIVIDEND_DEF,
  parameter int          OUT_W    = OUT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       freq_l,
  input  logic [31:0]       freq_r,
  input  logic [2:0]        octave,
  output logic [OUT_W-1:0]  note_div_left,
  output logic [OUT_W-1:0]  note_div_right,
  output logic              busy,
  output logic              upd_l,
  output logic              upd_r
);

  localparam int          DIV_BITS = $clog2(64'(DIVIDEND) + 64'd1);
  localparam int          CNT_W    = $clog2(DIV_BITS);
  localparam logic [63:0] OUT_MAX  = (64'd1 << OUT_W) - 64'd1;

  state_t              r_state;
  chan_t               r_chan;   // channel being served; doubles as last-granted
  logic [CNT_W-1:0]    r_cnt;
  logic                r_zero;
  logic                r_busy;
  logic                r_upd_l;
  logic                r_upd_r;
  logic [OUT_W-1:0]    r_div_l;
  logic [OUT_W-1:0]    r_div_r;
  logic [FREQ_W-1:0]   r_cap_l;
  logic [FREQ_W-1:0]   r_cap_r;
  logic                r_dirty_l;
  logic                r_dirty_r;

  logic [FREQ_W-1:0]   w_eff_l;
  logic [FREQ_W-1:0]   w_eff_r;
  logic [FREQ_W-1:0]   w_sel_eff;
  logic                w_load;
  logic                w_req;
  chan_t               w_grant;
  logic [DIV_BITS-1:0] w_dividend;
  logic [DIV_BITS-1:0] w_quot;
  logic                w_done;
  logic [63:0]         w_quot_ext;
  logic [OUT_W-1:0]    w_result;

  assign w_eff_l    = eff_freq(freq_l, octave);
  assign w_eff_r    = eff_freq(freq_r, octave);
  assign w_sel_eff  = (r_chan == CH_L) ? w_eff_l : w_eff_r;
  assign w_load     = (r_state == ST_LOAD);
  assign w_req      = r_dirty_l | r_dirty_r;
  assign w_dividend = DIV_BITS'(DIVIDEND);

  // Round-robin only matters when both channels are pending.
  assign w_grant = (r_dirty_l && r_dirty_r) ? ((r_chan == CH_R) ? CH_L : CH_R)
                 : (r_dirty_l ? CH_L : CH_R);

  // Silence bypasses the quotient; oversize quotients clamp to the output range.
  assign w_quot_ext = 64'(w_quot);
  assign w_result   = r_zero                 ? OUT_W'(SILENCE)
                    : (w_quot_ext > OUT_MAX) ? OUT_MAX[OUT_W-1:0]
                    :                          w_quot_ext[OUT_W-1:0];

  serial_divider #(
    .N  (DIV_BITS),
    .DW (FREQ_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (w_load),
    .dividend (w_dividend),
    .divisor  (w_sel_eff),
    .quotient (w_quot),
    .done     (w_done)
  );

  // Track per-channel changes of the effective frequency and capture on LOAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dirty_l <= 1'b1;
      r_dirty_r <= 1'b1;
      r_cap_l   <= '0;
      r_cap_r   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from the
      // same pre-edge values; the later clear below overrides the set for the
      // channel being captured.
      r_dirty_l <= r_dirty_l | (w_eff_l != r_cap_l);
      r_dirty_r <= r_dirty_r | (w_eff_r != r_cap_r);
      if (w_load) begin
        if (r_chan == CH_L) begin
          r_cap_l   <= w_eff_l;
          r_dirty_l <= 1'b0;
        end else begin
          r_cap_r   <= w_eff_r;
          r_dirty_r <= 1'b0;
        end
      end
    end
  end

  // Arbitration FSM: grant, load, wait out the division, write the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_chan  <= CH_R;
      r_cnt   <= '0;
      r_zero  <= 1'b0;
      r_busy  <= 1'b0;
      r_upd_l <= 1'b0;
      r_upd_r <= 1'b0;
      r_div_l <= OUT_W'(SILENCE);
      r_div_r <= OUT_W'(SILENCE);
    end else begin
      r_upd_l <= 1'b0;
      r_upd_r <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_chan  <= w_grant;
            r_busy  <= 1'b1;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_zero  <= (w_sel_eff == '0);
          r_cnt   <= '0;
          r_state <= ST_DIV;
        end
        ST_DIV: begin
          if (r_cnt == CNT_W'(DIV_BITS - 1)) r_state <= ST_WRITE;
          else                               r_cnt   <= r_cnt + 1'b1;
        end
        ST_WRITE: begin
          if (w_done) begin
            if (r_chan == CH_L) begin
              r_div_l <= w_result;
              r_upd_l <= 1'b1;
            end else begin
              r_div_r <= w_result;
              r_upd_r <= 1'b1;
            end
            // Chain straight into the next job so busy never drops between
            // back-to-back requests.
            if (w_req) begin
              r_chan  <= w_grant;
              r_state <= ST_LOAD;
            end else begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign note_div_left  = r_div_l;
  assign note_div_right = r_div_r;
  assign busy           = r_busy;
  assign upd_l          = r_upd_l;
  assign upd_r          = r_upd_r;

endmodule

// File: tb/tb_note_div_arbiter.sv
// Directed bench for note_div_arbiter: table of left-channel vectors plus
// hand-written sequences for arbitration, mid-division changes and reset.
module tb_note_div_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] freq_l;
  logic [31:0] freq_r;
  logic [2:0]  octave;
  logic [21:0] note_div_left;
  logic [21:0] note_div_right;
  logic        busy;
  logic        upd_l;
  logic        upd_r;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] fl;
    logic [2:0]  oct;
    logic [31:0] exp_l;
  } vec_t;

  vec_t vecs[10];

  note_div_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .freq_l         (freq_l),
    .freq_r         (freq_r),
    .octave         (octave),
    .note_div_left  (note_div_left),
    .note_div_right (note_div_right),
    .busy           (busy),
    .upd_l          (upd_l),
    .upd_r          (upd_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Step negedges until busy rises (the LOAD cycle), bounded.
  task automatic wait_load(input string name);
    int i = 0;
    while (!busy && i < 10) begin
      @(negedge clk);
      i++;
    end
    check(name, 32'(busy), 32'd1);
  endtask

  // Step from the current cycle until the chosen upd pulse, counting cycles.
  task automatic run_to_upd(input bit left, inout int lat);
    bit seen = 1'b0;
    while (!seen && lat < 200) begin
      @(negedge clk);
      lat++;
      seen = left ? upd_l : upd_r;
    end
  endtask

  initial begin
    int lat;
    int lat_l;
    int lat_r;
    int low;

    vecs[0] = '{32'd440,          3'd2, 32'd113636};
    vecs[1] = '{32'd440,          3'd3, 32'd56818};
    vecs[2] = '{32'd440,          3'd1, 32'd227272};
    vecs[3] = '{32'd262,          3'd2, 32'd190839};
    vecs[4] = '{32'd5,            3'd2, 32'd4194303};
    vecs[5] = '{32'd12,           3'd2, 32'd4166666};
    vecs[6] = '{32'd11,           3'd2, 32'd4194303};
    vecs[7] = '{32'h8000_0000,    3'd3, 32'd1};
    vecs[8] = '{32'd50_000_000,   3'd2, 32'd1};
    vecs[9] = '{32'd330,          3'd0, 32'd151515};

    // Scenario 1: reset state, then left 440 and right silent.
    rst    = 1'b1;
    freq_l = 32'd440;
    freq_r = 32'd0;
    octave = 3'd2;
    repeat (3) @(negedge clk);
    check("rst_left",  32'(note_div_left),  32'd1);
    check("rst_right", 32'(note_div_right), 32'd1);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_upd_l", 32'(upd_l), 32'd0);
    check("rst_upd_r", 32'(upd_r), 32'd0);
    rst = 1'b0;
    wait_load("s1_load");
    lat = 0;
    run_to_upd(1'b1, lat);
    check("s1_lat_l",  32'(lat), 32'd28);
    check("s1_left",   32'(note_div_left), 32'd113636);
    run_to_upd(1'b0, lat);
    check("s1_lat_r",  32'(lat), 32'd56);
    check("s1_right",  32'(note_div_right), 32'd1);
    check("s1_idle_busy", 32'(busy), 32'd0);
    @(negedge clk);

    // Scenario 3: both channels change together; left first, busy unbroken.
    freq_l = 32'd262;
    freq_r = 32'd330;
    wait_load("s3_load");
    lat = 0; lat_l = -1; lat_r = -1; low = 0;
    while (lat_r < 0 && lat < 200) begin
      @(negedge clk);
      lat++;
      if (upd_l && lat_l < 0) lat_l = lat;
      if (upd_r) lat_r = lat;
      else if (!busy) low++;
    end
    check("s3_lat_l",     32'(lat_l), 32'd28);
    check("s3_lat_r",     32'(lat_r), 32'd56);
    check("s3_busy_gaps", 32'(low),   32'd0);
    check("s3_left",      32'(note_div_left),  32'd190839);
    check("s3_right",     32'(note_div_right), 32'd151515);
    @(negedge clk);

    // Silence the right channel so octave changes only touch the left.
    freq_r = 32'd0;
    wait_load("sil_load");
    lat = 0;
    run_to_upd(1'b0, lat);
    check("sil_lat",   32'(lat), 32'd28);
    check("sil_right", 32'(note_div_right), 32'd1);
    check("sil_left_hold", 32'(note_div_left), 32'd190839);
    @(negedge clk);

    // Table: left-channel conversions, octave handling and saturation.
    for (int i = 0; i < 10; i++) begin
      freq_l = vecs[i].fl;
      octave = vecs[i].oct;
      wait_load($sformatf("row%0d_load", i));
      lat = 0;
      run_to_upd(1'b1, lat);
      check($sformatf("row%0d_lat", i),   32'(lat), 32'd28);
      check($sformatf("row%0d_left", i),  32'(note_div_left), vecs[i].exp_l);
      check($sformatf("row%0d_right", i), 32'(note_div_right), 32'd1);
      @(negedge clk);
      check($sformatf("row%0d_pulse", i), 32'(upd_l), 32'd0);
    end

    // Scenario 5: change during DIV; stale result first, then the new one.
    freq_l = 32'd440;
    octave = 3'd2;
    wait_load("s5_load");
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
    end
    freq_l = 32'd880;
    run_to_upd(1'b1, lat);
    check("s5_lat_1",  32'(lat), 32'd28);
    check("s5_left_1", 32'(note_div_left), 32'd113636);
    run_to_upd(1'b1, lat);
    check("s5_lat_2",  32'(lat), 32'd56);
    check("s5_left_2", 32'(note_div_left), 32'd56818);
    @(negedge clk);

    // Scenario 6: reset mid-division, then both channels recompute.
    freq_l = 32'd262;
    wait_load("s6_load");
    lat = 0;
    while (lat < 15) begin
      @(negedge clk);
      lat++;
    end
    rst    = 1'b1;
    freq_r = 32'd330;
    @(negedge clk);
    check("s6_rst_left",  32'(note_div_left),  32'd1);
    check("s6_rst_right", 32'(note_div_right), 32'd1);
    check("s6_rst_busy",  32'(busy),  32'd0);
    check("s6_rst_upd",   32'(upd_l), 32'd0);
    rst = 1'b0;
    wait_load("s6_reload");
    lat = 0;
    run_to_upd(1'b1, lat);
    check("s6_lat_l", 32'(lat), 32'd28);
    check("s6_left",  32'(note_div_left), 32'd190839);
    run_to_upd(1'b0, lat);
    check("s6_lat_r", 32'(lat), 32'd56);
    check("s6_right", 32'(note_div_right), 32'd151515);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/note_div_arbiter.md
NOTE_DIV_ARBITER -- requirements
Module: note_div_arbiter

Interface
REQ-001 Parameter DIVIDEND, default 50_000_000, numerator for the tone-to-divider conversion.
REQ-002 Parameter OUT_W, default 22, width of each output divider value.
REQ-003 clk  in  1  system clock; the single clock of the block.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 freq_l  in  32  raw left tone frequency in Hz; 0 = silence.
REQ-006 freq_r  in  32  raw right tone frequency in Hz; 0 = silence.
REQ-007 octave  in  3  octave select: 1 = down, 2 = normal, 3 = up, other = normal.
REQ-008 note_div_left  out  OUT_W  registered left divider value for the note generator.
REQ-009 note_div_right  out  OUT_W  registered right divider value.
REQ-010 busy  out  1  high while the shared divider is in use.
REQ-011 upd_l / upd_r  out  1 each  one-cycle pulse on the cycle the matching output register changes value or is rewritten.

Function
REQ-012 The effective frequency SHALL be freq>>1 for octave 1, freq<<1 (32-bit, overflow dropped) for octave 3, and freq otherwise; it is combinational per channel.
REQ-013 A per-channel dirty flag SHALL be set on any cycle where that channel's effective frequency differs from its last captured value; the flag is cleared when the channel is captured for division.
REQ-014 A single shared divider SHALL serve both channels; there SHALL be no second divider.
REQ-015 FSM states: IDLE, LOAD, DIV, WRITE.
REQ-016 IDLE -> LOAD when any dirty flag is set; both dirty: grant the channel not granted last (round-robin); after reset, last-granted = right, so left wins first.
REQ-017 LOAD captures the granted channel's effective frequency and channel ID, and clears that dirty flag.
REQ-018 DIV SHALL run a restoring division of DIVIDEND by the captured value, one quotient bit per cycle, exactly 26 cycles for the default DIVIDEND (ceil(log2(DIVIDEND+1)) in general).
REQ-019 WRITE updates the granted output register, pulses upd_l or upd_r, then returns to IDLE.
REQ-020 Latency from a dirty flag setting in IDLE to the upd pulse SHALL be 28 cycles (1 LOAD + 26 DIV + 1 WRITE).
REQ-021 Captured value 0 SHALL write 1 (silence) without a division; the FSM still passes through DIV and keeps the 28-cycle latency.
REQ-022 A quotient exceeding 2^OUT_W-1 SHALL saturate to 2^OUT_W-1.
REQ-023 An input change during DIV/WRITE SHALL NOT abort; the stale result is written, then the re-set dirty flag triggers recomputation.
REQ-024 busy SHALL be high in LOAD, DIV and WRITE and low in IDLE.
REQ-025 The output of the channel not being served SHALL hold its value.

Reset
REQ-026 On rst: note_div_left = note_div_right = 1; busy = 0; upd_l = upd_r = 0; FSM = IDLE; last-granted = right.
REQ-027 On rst: both dirty flags set; both captured values = 0. This forces a recompute of both channels after reset.
REQ-028 rst asserted mid-division SHALL abort the division and discard the partial result on the same clock edge.

Structure
REQ-029 Shared package note_div_pkg SHALL hold the FSM state enum, the DIVIDEND default, OUT_W, the divider iteration count and the silence value 1.
REQ-030 The iterative restoring divider SHALL be the sub-module serial_divider, with ports start, dividend, divisor, quotient and done; the arbiter FSM SHALL contain the arbitration and octave logic.

Verification
REQ-031 Scenario 1: reset, then freq_l = 440, freq_r = 0, octave = 2. Required: note_div_left = 113636 with upd_l 28 cycles after the first LOAD; note_div_right = 1 with upd_r 28 cycles later.
REQ-032 Scenario 2: steady state at 440, then octave 2 -> 3. Required: left = 56818; then octave 3 -> 1 gives left = 227272.
REQ-033 Scenario 3: freq_l and freq_r change to 262 and 330 in the same cycle from IDLE. Required: left = 190839 updates first at +28, right = 151515 updates at +56, busy stays continuously high.
REQ-034 Scenario 4: freq_l = 5. Required: note_div_left saturates to 4194303.
REQ-035 Scenario 5: freq_l changes 440 -> 880 at cycle 10 of DIV. Required: 113636 is written, then 56818 is written 28 cycles later.
REQ-036 Scenario 6: rst asserted at cycle 15 of DIV. Required: both outputs = 1 and busy = 0 on the next edge; both channels recompute after rst is released.
